// File: rtl/studio2_pkg.sv
// Shared constants, scan-code tables and key lookup type for the Studio II keypad model.
// Pad 1 and pad 2 each have ten keys; key k of a pad is the k-th entry of its scan-code table.
package studio2_pkg;

    localparam int KEYPAD_KEYS = 10;
    localparam int TOTAL_KEYS  = 2 * KEYPAD_KEYS;

    localparam logic [3:0] KEY_SEL_NONE = 4'hF;
    localparam logic [2:0] OUT_N_KEYSEL = 3'd2;

    localparam logic [7:0] PAD1_CODES [KEYPAD_KEYS] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    localparam logic [7:0] PAD2_CODES [KEYPAD_KEYS] = '{
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

    typedef struct packed {
        logic       valid;
        logic       pad;
        logic [3:0] idx;
    } key_lookup_t;

    // One-hot mask of the key addressed by the select latch; 10..15 select nothing.
    function automatic logic [KEYPAD_KEYS-1:0] key_sel_mask(input logic [3:0] sel);
        logic [KEYPAD_KEYS-1:0] mask;
        mask = '0;
        for (int i = 0; i < KEYPAD_KEYS; i++) begin
            if (sel == 4'(i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/studio2_keypad_if.sv
// Keypad-side signal bundle: PS/2 event word and CPU OUT bus in, EF flags and key state out.
// master drives the PS/2/CPU side; slave is the keypad block.
interface studio2_keypad_if;
    import studio2_pkg::*;

    logic [10:0]            ps2_key;
    logic                   io_out;
    logic [2:0]             io_n;
    logic [7:0]             io_dout;
    logic                   ef3_n;
    logic                   ef4_n;
    logic [3:0]             key_sel;
    logic [KEYPAD_KEYS-1:0] keys1;
    logic [KEYPAD_KEYS-1:0] keys2;

    modport master (
        output ps2_key, io_out, io_n, io_dout,
        input  ef3_n, ef4_n, key_sel, keys1, keys2
    );

    modport slave (
        input  ps2_key, io_out, io_n, io_dout,
        output ef3_n, ef4_n, key_sel, keys1, keys2
    );

endinterface

// File: rtl/studio2_ps2_keymap.sv
// Combinational PS/2 set-2 scan code to keypad key translation.
// Extended codes never map, so E0-prefixed keys sharing a base code are ignored.
module studio2_ps2_keymap
    import studio2_pkg::*;
(
    input  logic [7:0]  scan_code,
    input  logic        extended,
    output key_lookup_t lookup
);

    logic [KEYPAD_KEYS-1:0] hit1;
    logic [KEYPAD_KEYS-1:0] hit2;

    generate
        for (genvar gi = 0; gi < KEYPAD_KEYS; gi++) begin : g_cmp
            assign hit1[gi] = (scan_code == PAD1_CODES[gi]);
            assign hit2[gi] = (scan_code == PAD2_CODES[gi]);
        end
    endgenerate

    // Table entries are unique, so at most one hit bit is ever set.
    always_comb begin
        lookup = '0;
        if (!extended) begin
            for (int i = 0; i < KEYPAD_KEYS; i++) begin
                if (hit1[i]) begin
                    lookup.valid = 1'b1;
                    lookup.pad   = 1'b0;
                    lookup.idx   = 4'(i);
                end
                if (hit2[i]) begin
                    lookup.valid = 1'b1;
                    lookup.pad   = 1'b1;
                    lookup.idx   = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/studio2_keypad.sv
// RCA Studio II twin keypads: PS/2 make/break tracking with a minimum-press stretch,
// the OUT 2 key-select latch and the active-low EF3/EF4 flags seen by the CDP1802.
module studio2_keypad
    import studio2_pkg::*;
#(
    parameter int                   STRETCH_W = 16,
    parameter logic [STRETCH_W-1:0] STRETCH   = STRETCH_W'(40000)
) (
    input  logic             clk_sys,
    input  logic             reset,
    studio2_keypad_if.slave  kp
);

    logic                   toggle_reg;
    logic                   primed_reg;
    logic                   ps2_event;
    key_lookup_t            lookup;
    logic [TOTAL_KEYS-1:0]  key_bits;
    logic [3:0]             key_sel_reg;
    logic [KEYPAD_KEYS-1:0] sel_mask;
    logic                   ef3_n_reg;
    logic                   ef4_n_reg;
    logic                   latch_wr;
    logic                   unused_dout_hi;

    // The first clock after reset only learns the toggle level, so a stale toggle is not an event.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            toggle_reg <= 1'b0;
            primed_reg <= 1'b0;
        end else begin
            toggle_reg <= kp.ps2_key[10];
            primed_reg <= 1'b1;
        end
    end

    assign ps2_event = primed_reg && (kp.ps2_key[10] != toggle_reg);

    studio2_ps2_keymap u_keymap (
        .scan_code (kp.ps2_key[7:0]),
        .extended  (kp.ps2_key[8]),
        .lookup    (lookup)
    );

    // Slice gi: pad 1 keys 0..9 occupy gi 0..9, pad 2 keys occupy gi 10..19.
    generate
        for (genvar gi = 0; gi < TOTAL_KEYS; gi++) begin : g_key
            localparam logic       PAD = (gi >= KEYPAD_KEYS);
            localparam logic [3:0] IDX = 4'(gi % KEYPAD_KEYS);

            logic                 hit;
            logic                 make_ev;
            logic                 break_ev;
            logic [STRETCH_W-1:0] cnt_reg;
            logic                 pend_reg;
            logic                 bit_reg;

            assign hit      = ps2_event && lookup.valid && (lookup.pad == PAD) && (lookup.idx == IDX);
            assign make_ev  = hit && kp.ps2_key[9];
            assign break_ev = hit && !kp.ps2_key[9];

            // A make outranks a same-cycle expiry; a break during the stretch is deferred.
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    cnt_reg  <= '0;
                    pend_reg <= 1'b0;
                    bit_reg  <= 1'b0;
                end else if (make_ev) begin
                    cnt_reg  <= STRETCH;
                    pend_reg <= 1'b0;
                    bit_reg  <= 1'b1;
                end else begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - STRETCH_W'(1);
                    end
                    if (break_ev) begin
                        if (cnt_reg == '0) begin
                            bit_reg  <= 1'b0;
                            pend_reg <= 1'b0;
                        end else begin
                            pend_reg <= 1'b1;
                        end
                    end else if (pend_reg && (cnt_reg == '0)) begin
                        bit_reg  <= 1'b0;
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign key_bits[gi] = bit_reg;
        end
    endgenerate

    assign latch_wr = kp.io_out && (kp.io_n == OUT_N_KEYSEL);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            key_sel_reg <= KEY_SEL_NONE;
        end else if (latch_wr) begin
            key_sel_reg <= kp.io_dout[3:0];
        end
    end

    assign sel_mask = key_sel_mask(key_sel_reg);

    // Flags lag the key bitmap and select latch by one clock.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ef3_n_reg <= 1'b1;
            ef4_n_reg <= 1'b1;
        end else begin
            ef3_n_reg <= ~|(key_bits[KEYPAD_KEYS-1:0] & sel_mask);
            ef4_n_reg <= ~|(key_bits[TOTAL_KEYS-1:KEYPAD_KEYS] & sel_mask);
        end
    end

    assign unused_dout_hi = ^kp.io_dout[7:4];

    assign kp.ef3_n   = ef3_n_reg;
    assign kp.ef4_n   = ef4_n_reg;
    assign kp.key_sel = key_sel_reg;
    assign kp.keys1   = key_bits[KEYPAD_KEYS-1:0];
    assign kp.keys2   = key_bits[TOTAL_KEYS-1:KEYPAD_KEYS];

endmodule

// File: tb/tb_studio2_keypad.sv
// Scoreboard bench for studio2_keypad: a timeline model predicts every cycle's outputs,
// a negedge monitor pops and compares; directed scenarios are followed by random traffic.
module tb_studio2_keypad;

    localparam int S = 24;

    typedef struct packed {
        logic [9:0] keys1;
        logic [9:0] keys2;
        logic [3:0] sel;
        logic       ef3_n;
        logic       ef4_n;
    } obs_t;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    studio2_keypad_if kif ();

    studio2_keypad #(.STRETCH_W(16), .STRETCH(16'(S))) dut (
        .clk_sys (clk_sys),
        .reset   (rst),
        .kp      (kif)
    );

    logic [7:0] codes [20] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q [$];
    obs_t mon_e;
    obs_t mon_a;

    // Model: a key reads pressed from its make edge until max(break edge, make edge + S + 1).
    bit         m_made    [20];
    int         m_make_t  [20];
    int         m_clear_t [20];
    logic [3:0] m_sel;
    bit         m_primed;
    logic       m_tog;
    int         t_edge = 0;

    function automatic int find_key(input logic [7:0] c);
        for (int i = 0; i < 20; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    function automatic bit m_bit(input int k, input int t);
        return m_made[k] && (m_clear_t[k] < 0 || t < m_clear_t[k]);
    endfunction

    function automatic logic sel_hit(input logic [9:0] v, input logic [3:0] s);
        int si;
        si = int'(s);
        if (si > 9) return 1'b0;
        return v[si];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 20; i++) begin
            m_made[i] = 0; m_make_t[i] = 0; m_clear_t[i] = -1;
        end
        m_sel = 4'hF; m_primed = 0; m_tog = 1'b0;
    endtask

    task automatic model_edge();
        obs_t e;
        logic [9:0] p1, p2;
        bit ev;
        int k, c;
        t_edge++;
        for (int i = 0; i < 10; i++) begin
            p1[i] = m_bit(i, t_edge - 1);
            p2[i] = m_bit(10 + i, t_edge - 1);
        end
        e.ef3_n = ~sel_hit(p1, m_sel);
        e.ef4_n = ~sel_hit(p2, m_sel);
        ev = m_primed && (kif.ps2_key[10] != m_tog);
        m_tog = kif.ps2_key[10];
        m_primed = 1;
        if (ev && !kif.ps2_key[8]) begin
            k = find_key(kif.ps2_key[7:0]);
            if (k >= 0) begin
                if (kif.ps2_key[9]) begin
                    m_made[k] = 1; m_make_t[k] = t_edge; m_clear_t[k] = -1;
                end else if (m_bit(k, t_edge - 1)) begin
                    c = m_make_t[k] + S + 1;
                    m_clear_t[k] = (t_edge > c) ? t_edge : c;
                end
            end
        end
        if (kif.io_out && kif.io_n == 3'd2) m_sel = kif.io_dout[3:0];
        for (int i = 0; i < 10; i++) begin
            e.keys1[i] = m_bit(i, t_edge);
            e.keys2[i] = m_bit(10 + i, t_edge);
        end
        e.sel = m_sel;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic ps2(input logic [7:0] code, input bit pressed, input bit ext);
        kif.ps2_key = {~kif.ps2_key[10], pressed, ext, code};
        $display("ps2   t=%0d code=%02h pressed=%0d ext=%0d", t_edge + 1, code, pressed, ext);
        tick();
    endtask

    task automatic latch(input logic [7:0] d);
        kif.io_out = 1'b1; kif.io_n = 3'd2; kif.io_dout = d;
        $display("latch t=%0d data=%02h", t_edge + 1, d);
        tick();
        kif.io_out = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_keys1"}, 16'(kif.keys1), 16'h0);
        check({tag, "_keys2"}, 16'(kif.keys2), 16'h0);
        check({tag, "_sel"},   16'(kif.key_sel), 16'hF);
        check({tag, "_ef3"},   16'(kif.ef3_n), 16'h1);
        check({tag, "_ef4"},   16'(kif.ef4_n), 16'h1);
    endtask

    initial begin
        forever begin
            @(negedge clk_sys);
            if (!rst && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {kif.keys1, kif.keys2, kif.key_sel, kif.ef3_n, kif.ef4_n};
                checks++;
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0d actual=%h required=%h", t_edge, mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        bit ext, pressed;
        kif.ps2_key = {1'b1, 1'b1, 1'b0, 8'h45};
        kif.io_out = 1'b0; kif.io_n = 3'd0; kif.io_dout = 8'h00;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        idle(4);
        check("stale_toggle_keys1", 16'(kif.keys1), 16'h0);

        latch(8'h05);
        ps2(8'h2E, 1, 0);
        check("make_keys1", 16'(kif.keys1), 16'h020);
        check("make_ef3_lag", 16'(kif.ef3_n), 16'h1);
        tick();
        check("held_ef3", 16'(kif.ef3_n), 16'h0);
        idle(S + 5);
        ps2(8'h2E, 0, 0);
        check("break_keys1", 16'(kif.keys1), 16'h0);
        check("break_ef3_lag", 16'(kif.ef3_n), 16'h0);
        tick();
        check("released_ef3", 16'(kif.ef3_n), 16'h1);
        check("pad2_ef4", 16'(kif.ef4_n), 16'h1);

        ps2(8'h73, 1, 0);
        idle(10);
        ps2(8'h73, 0, 0);
        latch(8'h05);
        idle(3);
        check("stretch_keys2", 16'(kif.keys2), 16'h020);
        check("stretch_ef4", 16'(kif.ef4_n), 16'h0);
        idle(S);
        check("expired_keys2", 16'(kif.keys2), 16'h0);
        check("expired_ef4", 16'(kif.ef4_n), 16'h1);

        ps2(8'h26, 1, 0);
        ps2(8'h7A, 1, 0);
        latch(8'h03);
        tick();
        check("both_ef3", 16'(kif.ef3_n), 16'h0);
        check("both_ef4", 16'(kif.ef4_n), 16'h0);
        latch(8'h0C);
        tick();
        check("sel_c_ef3", 16'(kif.ef3_n), 16'h1);
        check("sel_c_ef4", 16'(kif.ef4_n), 16'h1);
        ps2(8'h26, 0, 0);
        ps2(8'h7A, 0, 0);
        idle(S + 3);

        ps2(8'h70, 1, 1);
        ps2(8'h1C, 1, 0);
        idle(2);
        check("ignored_keys1", 16'(kif.keys1), 16'h0);
        check("ignored_keys2", 16'(kif.keys2), 16'h0);

        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 9) < 8) code = codes[$urandom_range(0, 19)];
                else code = 8'($urandom);
                ext = ($urandom_range(0, 9) == 0);
                pressed = 1'($urandom_range(0, 1));
                kif.ps2_key = {~kif.ps2_key[10], pressed, ext, code};
                $display("ps2   t=%0d code=%02h pressed=%0d ext=%0d", t_edge + 1, code, pressed, ext);
            end
            kif.io_out  = ($urandom_range(0, 9) == 0);
            kif.io_n    = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
            kif.io_dout = 8'($urandom);
            if (kif.io_out) $display("out   t=%0d n=%0d data=%02h", t_edge + 1, kif.io_n, kif.io_dout);
            tick();
        end
        kif.io_out = 1'b0;
        idle(2);

        latch(8'h07);
        ps2(8'h3D, 1, 0);
        idle(3);
        ps2(8'h3D, 0, 0);
        idle(2);
        check("pre_reset_ef3", 16'(kif.ef3_n), 16'h0);
        @(negedge clk_sys);
        #2;
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        $display("reset asserted mid-cycle t=%0d", t_edge);
        check_reset_vals("async");
        repeat (2) @(posedge clk_sys);
        #1;
        rst = 1'b0;
        idle(S + 4);
        check("post_reset_keys1", 16'(kif.keys1), 16'h0);

        @(negedge clk_sys);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
